// File: rtl/dvg_pkg.sv
// dvg_pkg: shared definitions for the DVG instruction sequencer.
//   - opcode constants for the non-VCTR instructions
//   - sequencer state encoding
//   - sm2tc: 11-bit sign-magnitude to 11-bit two's complement
package dvg_pkg;

  localparam logic [3:0] OP_LABS = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hB;
  localparam logic [3:0] OP_JSRL = 4'hC;
  localparam logic [3:0] OP_RTSL = 4'hD;
  localparam logic [3:0] OP_JMPL = 4'hE;
  localparam logic [3:0] OP_SVEC = 4'hF;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_W0L,
    ST_W0H,
    ST_W0C,
    ST_W1L,
    ST_W1H,
    ST_W1C,
    ST_EXEC,
    ST_EMIT
  } state_e;

  // sm[10] is the sign, sm[9:0] the magnitude; negative zero maps to zero.
  function automatic logic [10:0] sm2tc(input logic [10:0] sm);
    logic [10:0] mag;
    mag = {1'b0, sm[9:0]};
    return sm[10] ? (~mag + 11'd1) : mag;
  endfunction

endpackage

// File: rtl/dvg_stack.sv
// dvg_stack: subroutine return-address LIFO for the DVG sequencer.
// Ports:
//   clk, reset     - clock, synchronous active-high reset (pointer only)
//   clear          - pointer back to 0 (sequencer restart); wins over push/pop
//   push, pop      - one operation per cycle; push wins if both are set
//   push_data      - 12-bit return address to store at stack[sp]
//   top_data       - stack[sp-1], the entry a pop returns
// STACK_DEPTH must be a power of two >= 2; the pointer wraps silently, so a
// push on a full stack overwrites the oldest entry and a pop on an empty one
// returns whatever the wrapped slot holds.
module dvg_stack #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  logic [11:0] push_data,
  output logic [11:0] top_data
);

  localparam int unsigned PW = $clog2(STACK_DEPTH);

  logic [PW-1:0] sp_q, sp_d;
  logic [11:0]   mem_q [STACK_DEPTH];
  logic [11:0]   mem_d [STACK_DEPTH];

  always_comb begin
    sp_d = sp_q;
    mem_d = mem_q;
    if (clear) begin
      sp_d = '0;
    end else if (push) begin
      mem_d[sp_q] = push_data;
      sp_d = sp_q + 1'b1;
    end else if (pop) begin
      sp_d = sp_q - 1'b1;
    end
  end

  assign top_data = mem_q[sp_q - 1'b1];

  always_ff @(posedge clk) begin
    if (reset) sp_q <= '0;
    else       sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/dvg_sequencer.sv
// dvg_sequencer: digital vector generator instruction sequencer.
// Fetches 16-bit instruction words byte-by-byte from vector memory, decodes
// VCTR/LABS/SVEC/JSRL/RTSL/JMPL/HALT and emits beam commands on a
// valid/ready stream.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   go                    - one-cycle restart pulse (pc, sp cleared)
//   halted                - 1 while idle
//   mem_addr / mem_data   - byte address out, read data one cycle later
//   cmd_valid / cmd_ready - beam command handshake
//   cmd_abs, cmd_x, cmd_y, cmd_scale, cmd_z - beam command fields
//   err                   - sticky watchdog abort flag
// Optional: define DVG_WATCHDOG_EN to force a halt with err=1 after
// WDOG_LIMIT executed instructions; otherwise err is tied low.
module dvg_sequencer
  import dvg_pkg::*;
#(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned WDOG_LIMIT  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  output logic        halted,
  output logic [12:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        cmd_abs,
  output logic [10:0] cmd_x,
  output logic [10:0] cmd_y,
  output logic [3:0]  cmd_scale,
  output logic [3:0]  cmd_z,
  output logic        err
);

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic        halted_q, halted_d;
  logic [3:0]  gscale_q, gscale_d;
  logic [7:0]  lo_q, lo_d;
  logic [15:0] w0_q, w0_d;
  // word1 minus its unused bit 11: [14:11]=z/gscale, [10:0]=sign-magnitude x
  logic [14:0] w1_q, w1_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        cmd_abs_q, cmd_abs_d;
  logic [10:0] cmd_x_q, cmd_x_d;
  logic [10:0] cmd_y_q, cmd_y_d;
  logic [3:0]  cmd_scale_q, cmd_scale_d;
  logic [3:0]  cmd_z_q, cmd_z_d;

  logic        stk_clear, stk_push, stk_pop;
  logic [11:0] stk_top;
  logic [3:0]  op, fetch_op;
  logic        need_w1;

  assign op       = w0_q[15:12];
  assign fetch_op = mem_data[7:4];
  assign need_w1  = (fetch_op <= OP_LABS) || (fetch_op == OP_JSRL) || (fetch_op == OP_JMPL);

`ifdef DVG_WATCHDOG_EN
  localparam int unsigned WCW = $clog2(WDOG_LIMIT + 1);
  localparam logic [WCW-1:0] WDOG_MAX = WCW'(WDOG_LIMIT);
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic           err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  dvg_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk       (clk),
    .reset     (reset),
    .clear     (stk_clear),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_q),
    .top_data  (stk_top)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    halted_d    = halted_q;
    gscale_d    = gscale_q;
    lo_d        = lo_q;
    w0_d        = w0_q;
    w1_d        = w1_q;
    cmd_valid_d = cmd_valid_q;
    cmd_abs_d   = cmd_abs_q;
    cmd_x_d     = cmd_x_q;
    cmd_y_d     = cmd_y_q;
    cmd_scale_d = cmd_scale_q;
    cmd_z_d     = cmd_z_q;
    stk_clear   = 1'b0;
    stk_push    = 1'b0;
    stk_pop     = 1'b0;
`ifdef DVG_WATCHDOG_EN
    wcnt_d      = wcnt_q;
    err_d       = err_q;
`endif

    case (state_q)
      ST_W0L: state_d = ST_W0H;
      ST_W0H: begin
        lo_d    = mem_data;
        state_d = ST_W0C;
      end
      ST_W0C: begin
        w0_d    = {mem_data, lo_q};
        pc_d    = pc_q + 12'd1;
        state_d = need_w1 ? ST_W1L : ST_EXEC;
      end
      ST_W1L: state_d = ST_W1H;
      ST_W1H: begin
        lo_d    = mem_data;
        state_d = ST_W1C;
      end
      ST_W1C: begin
        w1_d    = {mem_data[7:4], mem_data[2:0], lo_q};
        pc_d    = pc_q + 12'd1;
        state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_W0L;
        if (op <= 4'd9) begin
          cmd_abs_d   = 1'b0;
          cmd_x_d     = sm2tc(w1_q[10:0]);
          cmd_y_d     = sm2tc(w0_q[10:0]);
          cmd_z_d     = w1_q[14:11];
          cmd_scale_d = op + gscale_q;
          cmd_valid_d = 1'b1;
          state_d     = ST_EMIT;
        end else begin
          case (op)
            OP_LABS: begin
              cmd_abs_d   = 1'b1;
              cmd_x_d     = {1'b0, w1_q[9:0]};
              cmd_y_d     = {1'b0, w0_q[9:0]};
              cmd_z_d     = 4'd0;
              cmd_scale_d = w1_q[14:11];
              gscale_d    = w1_q[14:11];
              cmd_valid_d = 1'b1;
              state_d     = ST_EMIT;
            end
            OP_HALT: begin
              halted_d = 1'b1;
              state_d  = ST_IDLE;
            end
            OP_JSRL: begin
              stk_push = 1'b1;
              pc_d     = w0_q[11:0];
            end
            OP_RTSL: begin
              stk_pop = 1'b1;
              pc_d    = stk_top;
            end
            OP_JMPL: pc_d = w0_q[11:0];
            default: begin  // OP_SVEC
              cmd_abs_d   = 1'b0;
              cmd_x_d     = sm2tc({w0_q[2], w0_q[1:0], 8'h00});
              cmd_y_d     = sm2tc({w0_q[10], w0_q[9:8], 8'h00});
              cmd_z_d     = w0_q[7:4];
              cmd_scale_d = {2'b00, w0_q[11], w0_q[3]} + 4'd2 + gscale_q;
              cmd_valid_d = 1'b1;
              state_d     = ST_EMIT;
            end
          endcase
        end
`ifdef DVG_WATCHDOG_EN
        // The limit-reaching instruction is suppressed, not executed.
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_d == WDOG_MAX) begin
          halted_d    = 1'b1;
          err_d       = 1'b1;
          cmd_valid_d = 1'b0;
          stk_push    = 1'b0;
          stk_pop     = 1'b0;
          state_d     = ST_IDLE;
        end
`endif
      end
      ST_EMIT: begin
        if (cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = ST_W0L;
        end
      end
      default: ;  // ST_IDLE
    endcase

    // Restart overrides whatever the current state decided.
    if (go) begin
      state_d     = ST_W0L;
      pc_d        = '0;
      halted_d    = 1'b0;
      cmd_valid_d = 1'b0;
      stk_clear   = 1'b1;
      stk_push    = 1'b0;
      stk_pop     = 1'b0;
`ifdef DVG_WATCHDOG_EN
      wcnt_d      = '0;
      err_d       = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= '0;
      halted_q    <= 1'b1;
      gscale_q    <= '0;
      lo_q        <= '0;
      w0_q        <= '0;
      w1_q        <= '0;
      cmd_valid_q <= 1'b0;
      cmd_abs_q   <= 1'b0;
      cmd_x_q     <= '0;
      cmd_y_q     <= '0;
      cmd_scale_q <= '0;
      cmd_z_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      halted_q    <= halted_d;
      gscale_q    <= gscale_d;
      lo_q        <= lo_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_abs_q   <= cmd_abs_d;
      cmd_x_q     <= cmd_x_d;
      cmd_y_q     <= cmd_y_d;
      cmd_scale_q <= cmd_scale_d;
      cmd_z_q     <= cmd_z_d;
    end
  end

`ifdef DVG_WATCHDOG_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wcnt_q <= wcnt_d;
      err_q  <= err_d;
    end
  end
`endif

  assign mem_addr  = {pc_q, (state_q == ST_W0H) || (state_q == ST_W1H)};
  assign halted    = halted_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_abs   = cmd_abs_q;
  assign cmd_x     = cmd_x_q;
  assign cmd_y     = cmd_y_q;
  assign cmd_scale = cmd_scale_q;
  assign cmd_z     = cmd_z_q;

endmodule

// File: tb/tb_dvg_sequencer.sv
// tb_dvg_sequencer: directed + randomized bench for dvg_sequencer with an
// instruction-level reference interpreter for the vector program.
module tb_dvg_sequencer;

  localparam int DEPTH = 4;
`ifdef DVG_WATCHDOG_EN
  localparam int WDOG  = 16;
  localparam bit WD_ON = 1'b1;
`else
  localparam int WDOG  = 4096;
  localparam bit WD_ON = 1'b0;
`endif

  logic        clk, reset, go, halted, cmd_valid, cmd_ready, cmd_abs, err;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic [10:0] cmd_x, cmd_y;
  logic [3:0]  cmd_scale, cmd_z;

  dvg_sequencer #(.STACK_DEPTH(DEPTH), .WDOG_LIMIT(WDOG)) dut (
    .clk(clk), .reset(reset), .go(go), .halted(halted),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_abs(cmd_abs),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_scale(cmd_scale), .cmd_z(cmd_z),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [8192];
  always @(posedge clk) mem_data <= mem[mem_addr];

  typedef struct { int ab; int x; int y; int sc; int z; } cmd_t;
  cmd_t exp_q[$];
  int   m_stack [DEPTH];
  int   m_gs = 0;
  int   checks = 0, errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic put(input int a, input int w);
    mem[2*a]   = 8'(w & 255);
    mem[2*a+1] = 8'((w >> 8) & 255);
  endtask

  function automatic int rdw(input int a);
    return {16'h0000, mem[2*a+1], mem[2*a]};
  endfunction

  function automatic int smv(input int w);
    int mag = w & 1023;
    return ((w >> 10) & 1) != 0 ? -mag : mag;
  endfunction

  function automatic int fields();
    return int'({cmd_abs, cmd_x, cmd_y, cmd_scale, cmd_z});
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) put(i, 16'hB000);
  endtask

  // Instruction-level interpreter of the vector program in mem.
  task automatic run_model(output bit halts, output bit errs);
    int pc, sp, steps, w0, w1, op;
    cmd_t c;
    pc = 0; sp = 0; steps = 0; halts = 0; errs = 0;
    exp_q.delete();
    while (steps < 80) begin
      w0 = rdw(pc); pc = (pc + 1) % 4096; op = (w0 >> 12) & 15; w1 = 0;
      if (op <= 10 || op == 12 || op == 14) begin
        w1 = rdw(pc); pc = (pc + 1) % 4096;
      end
      steps++;
      if (WD_ON && steps == WDOG) begin halts = 1; errs = 1; return; end
      c.ab = 0; c.x = 0; c.y = 0; c.sc = -1; c.z = 0;
      if (op <= 9) begin
        c.x = smv(w1); c.y = smv(w0); c.z = (w1 >> 12) & 15;
        c.sc = (op + m_gs) % 16;
        exp_q.push_back(c);
      end else if (op == 10) begin
        c.ab = 1; c.x = w1 & 1023; c.y = w0 & 1023;
        m_gs = (w1 >> 12) & 15;
        exp_q.push_back(c);
      end else if (op == 11) begin
        halts = 1; return;
      end else if (op == 12) begin
        m_stack[sp] = pc; sp = (sp + 1) % DEPTH; pc = w0 & 4095;
      end else if (op == 13) begin
        sp = (sp + DEPTH - 1) % DEPTH; pc = m_stack[sp];
      end else if (op == 14) begin
        pc = w0 & 4095;
      end else begin
        c.y = smv((((w0 >> 10) & 1) << 10) | (((w0 >> 8) & 3) << 8));
        c.x = smv((((w0 >> 2) & 1) << 10) | ((w0 & 3) << 8));
        c.z = (w0 >> 4) & 15;
        c.sc = (((w0 >> 11) & 1) * 2 + ((w0 >> 3) & 1) + 2 + m_gs) % 16;
        exp_q.push_back(c);
      end
    end
  endtask

  task automatic cmp_cmd(input string tag, input cmd_t c);
    chk({tag, "_abs"}, int'(cmd_abs), c.ab);
    chk({tag, "_x"}, int'($signed(cmd_x)), c.x);
    chk({tag, "_y"}, int'($signed(cmd_y)), c.y);
    chk({tag, "_z"}, int'(cmd_z), c.z);
    if (c.sc >= 0) chk({tag, "_scale"}, int'(cmd_scale), c.sc);
  endtask

  task automatic pulse_go();
    @(negedge clk); go = 1'b1; cmd_ready = 1'b0;
    @(negedge clk); go = 1'b0;
  endtask

  // Drains expected commands with random backpressure, checking stability.
  task automatic collect(input string tag, input int pct, input bit exp_halt,
                         input bit exp_err, input int budget, output int gap);
    int cyc = 0, last = 0, prev = 0;
    bit pend = 0, done = 0;
    cmd_t c;
    while (!done && cyc < budget) begin
      @(negedge clk); cyc++;
      if (pend) begin
        chk({tag, "_hold_valid"}, int'(cmd_valid), 1);
        chk({tag, "_hold_fields"}, fields(), prev);
      end
      if (exp_q.size() == 0 && (!exp_halt || halted)) begin
        done = 1; cmd_ready = 1'b0;
      end else begin
        cmd_ready = (exp_q.size() != 0) && ($urandom_range(99) < pct);
        if (cmd_valid && cmd_ready) begin
          c = exp_q.pop_front();
          cmp_cmd(tag, c);
          last = cyc;
        end
      end
      pend = cmd_valid && !cmd_ready;
      prev = fields();
    end
    cmd_ready = 1'b0;
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_halted"}, int'(halted), int'(exp_halt));
    chk({tag, "_err"}, int'(err), int'(exp_err));
    gap = cyc - last;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!cmd_valid && n < 200) begin @(negedge clk); n++; end
    chk({tag, "_valid_seen"}, int'(cmd_valid), 1);
  endtask

  initial begin
    bit h, e;
    int gap, f0, seen, a, k, w;
    int base [5] = '{'h100, 'h200, 'h300, 'h380, 'h3C0};
    cmd_t c;

    reset = 1'b1; go = 1'b0; cmd_ready = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    reset = 1'b0; m_gs = 0;
    chk("rst_halted", int'(halted), 1);
    chk("rst_valid", int'(cmd_valid), 0);
    chk("rst_x", int'(cmd_x), 0);
    chk("rst_y", int'(cmd_y), 0);
    chk("rst_abs", int'(cmd_abs), 0);
    chk("rst_scale", int'(cmd_scale), 0);
    chk("rst_z", int'(cmd_z), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_addr", int'(mem_addr), 0);

    // VCTR op=2 y=+5 x=-3 z=7, HALT
    put(0, 'h2005); put(1, 'h7403); put(2, 'hB000);
    run_model(h, e); pulse_go();
    collect("basic", 100, h, e, 200, gap);
    chk("basic_halt_latency", int'(gap <= 10), 1);

    // Same program with 20 cycles of backpressure
    run_model(h, e); pulse_go();
    wait_valid("stall");
    chk("stall_x", int'($signed(cmd_x)), -3);
    chk("stall_y", int'($signed(cmd_y)), 5);
    chk("stall_scale", int'(cmd_scale), 2);
    chk("stall_z", int'(cmd_z), 7);
    chk("stall_abs", int'(cmd_abs), 0);
    chk("stall_addr", int'(mem_addr), 4);
    f0 = fields();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("stall_valid", int'(cmd_valid), 1);
      chk("stall_fields", fields(), f0);
      chk("stall_addr_hold", int'(mem_addr), 4);
    end
    cmd_ready = 1'b1;
    c = exp_q.pop_front();
    cmp_cmd("stall_acc", c);
    @(negedge clk);
    chk("stall_accepted", int'(cmd_valid), 0);
    collect("stall_tail", 100, h, e, 100, gap);

    // LABS x=0x200 y=0x180 gscale=1, then VCTR op=9; then gscale=8 wrap
    for (int v = 0; v < 2; v++) begin
      clear_mem();
      put(0, 'hA180); put(1, v == 0 ? 'h1200 : 'h8200);
      put(2, 'h9000 | $urandom_range(4095)); put(3, $urandom_range(65535));
      run_model(h, e); pulse_go();
      collect(v == 0 ? "labs" : "labs_wrap", 60, h, e, 400, gap);
    end

    // Random emitting programs
    for (int t = 0; t < 8; t++) begin
      clear_mem(); a = 0;
      for (int i = 0; i < int'($urandom_range(6, 2)); i++) begin
        k = $urandom_range(2);
        if (k == 0) begin
          put(a, ($urandom_range(9) << 12) | $urandom_range(4095));
          put(a + 1, $urandom_range(65535)); a += 2;
        end else if (k == 1) begin
          put(a, 'hF000 | $urandom_range(4095)); a += 1;
        end else begin
          put(a, 'hA000 | $urandom_range(4095));
          put(a + 1, $urandom_range(65535)); a += 2;
        end
      end
      put(a, 'hB000);
      run_model(h, e); pulse_go();
      collect("rand", 50, h, e, 1000, gap);
    end

    // Five nested JSRLs on a four-entry stack
    clear_mem();
    put(0, 'hC100); put(1, 0);
    for (int i = 0; i < 5; i++) begin
      put(base[i], 'hF000 | ($urandom_range(4095) & 'hF0F) | (i << 4));
      if (i < 4) begin
        put(base[i] + 1, 'hC000 | base[i + 1]); put(base[i] + 2, 0);
        put(base[i] + 3, 'hF000 | ($urandom_range(4095) & 'hF0F) | ((i + 8) << 4));
        put(base[i] + 4, 'hD000);
      end else begin
        put(base[i] + 1, 'hD000);
      end
    end
    run_model(h, e); pulse_go();
    collect("jsrl", 70, h, e, 3000, gap);

    // go while in EMIT: restart from 0 with sp cleared
    clear_mem();
    for (int i = 0; i < 5; i++) begin
      put(i * 16, 'hC000 | ((i + 1) * 16)); put(i * 16 + 1, 0);
    end
    put('h50, 'hF000 | 'h5A5); put('h51, 'hB000);
    run_model(h, e);
    pulse_go();
    wait_valid("goemit");
    w = 'h0400 | $urandom_range(1023);
    put(0, 'hD000);
    put('h32, 'h3000 | w); put('h33, 'h1000 | $urandom_range(2047)); put('h34, 'hB000);
    put('h42, 'hF2F0); put('h43, 'hB000);
    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    chk("goemit_valid_drop", int'(cmd_valid), 0);
    chk("goemit_addr", int'(mem_addr), 0);
    chk("goemit_halted", int'(halted), 0);
    run_model(h, e);
    collect("goemit", 80, h, e, 400, gap);

    // Reset while a command is pending: nothing is delivered afterwards
    clear_mem();
    put(0, 'h4123); put(1, 'h5456);
    run_model(h, e); pulse_go();
    wait_valid("midrst");
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; m_gs = 0; exp_q.delete();
    chk("midrst_valid", int'(cmd_valid), 0);
    chk("midrst_halted", int'(halted), 1);
    chk("midrst_x", int'(cmd_x), 0);
    chk("midrst_addr", int'(mem_addr), 0);
    cmd_ready = 1'b1; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_valid) seen++;
    end
    cmd_ready = 1'b0;
    chk("midrst_no_cmd", seen, 0);

    // JMPL 0 loop: watchdog abort, or runs forever without it
    clear_mem();
    put(0, 'hE000); put(1, 0);
    run_model(h, e); pulse_go();
    collect("loop", 100, h, e, 400, gap);
    repeat (50) @(negedge clk);
    chk("loop_halted", int'(halted), int'(WD_ON));
    chk("loop_err", int'(err), int'(WD_ON));
    pulse_go();
    chk("loop_go_err", int'(err), 0);
    chk("loop_go_halted", int'(halted), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
